// File: rtl/counter_underflow_if.sv
// ---------------------------------------------------------------------------
// counter_underflow_if
// Groups the control and status signals of the countdown timer.
//   i_LOAD      load strobe, samples i_INIT
//   i_INIT      start value (COUNTER_BITS wide)
//   i_EN        count enable
//   o_COUNT     current registered count
//   o_UNDERFLOW registered zero-reached flag
//   o_BUSY      registered, high while counting or paused
// Modports: master drives the strobes and observes status, slave is the timer.
// ---------------------------------------------------------------------------
interface counter_underflow_if #(
    parameter int COUNTER_BITS = 32
);
    logic                    i_LOAD;
    logic [COUNTER_BITS-1:0] i_INIT;
    logic                    i_EN;
    logic [COUNTER_BITS-1:0] o_COUNT;
    logic                    o_UNDERFLOW;
    logic                    o_BUSY;

    modport master (
        output i_LOAD,
        output i_INIT,
        output i_EN,
        input  o_COUNT,
        input  o_UNDERFLOW,
        input  o_BUSY
    );

    modport slave (
        input  i_LOAD,
        input  i_INIT,
        input  i_EN,
        output o_COUNT,
        output o_UNDERFLOW,
        output o_BUSY
    );
endinterface

// File: rtl/counter_underflow.sv
// ---------------------------------------------------------------------------
// counter_underflow
// Loadable down-counter that flags when it reaches zero.
//   i_CLK    single clock, all state changes on its rising edge
//   i_RST_N  asynchronous active-low reset (forces IDLE, all outputs 0)
//   bus      counter_underflow_if.slave: i_LOAD/i_INIT/i_EN in,
//            o_COUNT/o_UNDERFLOW/o_BUSY out (all outputs registered)
// States: IDLE (after reset), RUN, PAUSE (enable low), DONE (zero reached).
// Optional feature: define COUNTER_UNDERFLOW_AUTORELOAD_EN for periodic mode,
// where reaching zero reloads the last loaded value, pulses o_UNDERFLOW for a
// single cycle and keeps running.
// ---------------------------------------------------------------------------
module counter_underflow #(
    parameter int COUNTER_BITS = 32
) (
    input  logic                 i_CLK,
    input  logic                 i_RST_N,
    counter_underflow_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [COUNTER_BITS-1:0] CNT_ZERO = {COUNTER_BITS{1'b0}};
    localparam logic [COUNTER_BITS-1:0] CNT_ONE  = {{(COUNTER_BITS-1){1'b0}}, 1'b1};

    state_t                  state_r;
    logic [COUNTER_BITS-1:0] count_r;
    logic [COUNTER_BITS-1:0] reload_r;
    logic                    underflow_r;
    logic                    busy_r;
    logic                    zero_reach_s;

    // Flags the enabled edge that takes the count to zero; "<=" rather than
    // "==" keeps the decrement from ever wrapping even from a corrupted zero.
    always_comb begin
        zero_reach_s = 1'b0;
        if (count_r <= CNT_ONE) begin
            zero_reach_s = 1'b1;
        end else begin
            zero_reach_s = 1'b0;
        end
    end

    // Single state machine: load has priority, then countdown / pause,
    // with busy and underflow registered alongside the next state.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_r     <= IDLE;
            count_r     <= CNT_ZERO;
            reload_r    <= CNT_ZERO;
            underflow_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (bus.i_LOAD) begin
            count_r  <= bus.i_INIT;
            reload_r <= bus.i_INIT;
            if (bus.i_INIT == CNT_ZERO) begin
                state_r     <= DONE;
                underflow_r <= 1'b1;
                busy_r      <= 1'b0;
            end else if (bus.i_EN) begin
                state_r     <= RUN;
                underflow_r <= 1'b0;
                busy_r      <= 1'b1;
            end else begin
                state_r     <= PAUSE;
                underflow_r <= 1'b0;
                busy_r      <= 1'b1;
            end
        end else begin
            case (state_r)
                RUN, PAUSE: begin
                    if (bus.i_EN) begin
                        if (zero_reach_s) begin
`ifdef COUNTER_UNDERFLOW_AUTORELOAD_EN
                            // Periodic mode: restart from the loaded value.
                            count_r     <= reload_r;
                            underflow_r <= 1'b1;
                            state_r     <= RUN;
                            busy_r      <= 1'b1;
`else
                            count_r     <= CNT_ZERO;
                            underflow_r <= 1'b1;
                            state_r     <= DONE;
                            busy_r      <= 1'b0;
`endif
                        end else begin
                            count_r     <= count_r - CNT_ONE;
                            underflow_r <= 1'b0;
                            state_r     <= RUN;
                            busy_r      <= 1'b1;
                        end
                    end else begin
                        underflow_r <= 1'b0;
                        state_r     <= PAUSE;
                        busy_r      <= 1'b1;
                    end
                end
                DONE: begin
                    count_r     <= CNT_ZERO;
                    underflow_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= DONE;
                end
                IDLE: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    count_r     <= CNT_ZERO;
                    underflow_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

`ifndef COUNTER_UNDERFLOW_AUTORELOAD_EN
    // The reload value is captured on every load but only read in periodic
    // mode; this reduction just marks it as intentionally unread here.
    logic unused_reload_s;
    assign unused_reload_s = ^reload_r;
`endif

    assign bus.o_COUNT     = count_r;
    assign bus.o_UNDERFLOW = underflow_r;
    assign bus.o_BUSY      = busy_r;

endmodule

// File: tb/tb_counter_underflow.sv
// ---------------------------------------------------------------------------
// tb_counter_underflow
// Self-checking bench for counter_underflow: a vector table of directed
// scenarios, hand-written reset / periodic sequences, then random stimulus
// compared against a simple behavioural model of the countdown rules.
// ---------------------------------------------------------------------------
module tb_counter_underflow;

    localparam int CB = 16;
`ifdef COUNTER_UNDERFLOW_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    typedef struct {
        bit            load;
        logic [CB-1:0] init;
        bit            en;
        logic [CB-1:0] exp_count;
        bit            exp_uf;
        bit            exp_busy;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // behavioural model
    logic [CB-1:0] m_count;
    logic [CB-1:0] m_reload;
    bit            m_uf;
    bit            m_active;

    counter_underflow_if #(.COUNTER_BITS(CB)) bus ();

    counter_underflow #(.COUNTER_BITS(CB)) dut (
        .i_CLK   (clk),
        .i_RST_N (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input longint c, input bit u, input bit b);
        check({tag, ".count"}, longint'(bus.o_COUNT), c);
        check({tag, ".underflow"}, longint'(bus.o_UNDERFLOW), longint'(u));
        check({tag, ".busy"}, longint'(bus.o_BUSY), longint'(b));
    endtask

    // Drive inputs, take one rising edge, sample 1 ns later.
    task automatic step(input bit ld, input logic [CB-1:0] ini, input bit e);
        bus.i_LOAD = ld;
        bus.i_INIT = ini;
        bus.i_EN   = e;
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, check outputs clear at once, release it
    // before the next rising edge.
    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check_all(tag, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m_count = '0; m_reload = '0; m_uf = 1'b0; m_active = 1'b0;
    endtask

    // Model of the countdown rules for one edge.
    task automatic model_edge(input bit ld, input logic [CB-1:0] ini, input bit e);
        if (ld) begin
            m_count  = ini;
            m_reload = ini;
            m_uf     = (ini == 0);
            m_active = (ini != 0);
        end else if (m_active && e) begin
            if (m_count == 1) begin
                m_uf = 1'b1;
                if (AR) m_count = m_reload;
                else begin
                    m_count  = 0;
                    m_active = 1'b0;
                end
            end else begin
                m_count = m_count - 1;
                m_uf    = 1'b0;
            end
        end else if (m_active) begin
            m_uf = 1'b0;
        end
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(bit ld, int ini, bit e, int c, bit u, bit b);
        vec_t v;
        v.load = ld; v.init = CB'(ini); v.en = e;
        v.exp_count = CB'(c); v.exp_uf = u; v.exp_busy = b;
        return v;
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.i_LOAD = 1'b0;
        bus.i_INIT = '0;
        bus.i_EN   = 1'b0;
        m_count = '0; m_reload = '0; m_uf = 1'b0; m_active = 1'b0;

        // load 5 and count to zero
        vecs.push_back(mk(1, 5, 1, 5, 0, 1));
        vecs.push_back(mk(0, 0, 1, 4, 0, 1));
        vecs.push_back(mk(0, 0, 1, 3, 0, 1));
        vecs.push_back(mk(0, 0, 1, 2, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, AR ? 5 : 0, 1, AR));
        // load 4 with a 3-edge pause
        vecs.push_back(mk(1, 4, 1, 4, 0, 1));
        vecs.push_back(mk(0, 0, 1, 3, 0, 1));
        vecs.push_back(mk(0, 0, 1, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 2, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, AR ? 4 : 0, 1, AR));
        // load 0 goes straight to done, enable ignored
        vecs.push_back(mk(1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0));
        // load 7 on the zero-reach edge wins
        vecs.push_back(mk(1, 2, 1, 2, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(1, 7, 1, 7, 0, 1));
        vecs.push_back(mk(0, 0, 1, 6, 0, 1));
        // load while paused, then pause-loaded resume
        vecs.push_back(mk(1, 3, 0, 3, 0, 1));
        vecs.push_back(mk(0, 0, 0, 3, 0, 1));
        vecs.push_back(mk(0, 0, 1, 2, 0, 1));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // idle ignores enable
        step(1'b0, CB'(9), 1'b1);
        check_all("idle_en", 0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].load, vecs[i].init, vecs[i].en);
            check_all($sformatf("vec%0d", i), longint'(vecs[i].exp_count),
                      vecs[i].exp_uf, vecs[i].exp_busy);
        end

        // reset mid-count at 3, then enable alone stays idle
        step(1'b1, CB'(5), 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        check_all("pre_rst", 3, 1'b0, 1'b1);
        async_reset("mid_rst");
        step(1'b0, '0, 1'b1);
        check_all("post_rst_en", 0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1);
        check_all("post_rst_en2", 0, 1'b0, 1'b0);

        // load on the first edge after release is honoured
        async_reset("rst2");
        step(1'b1, CB'(9), 1'b0);
        check_all("first_edge_load", 9, 1'b0, 1'b1);

`ifdef COUNTER_UNDERFLOW_AUTORELOAD_EN
        // periodic mode: 2,1,3,2,1,3 with single-cycle pulses
        step(1'b1, CB'(3), 1'b1);
        check_all("ar_load", 3, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, '0, 1'b1);
            check_all($sformatf("ar%0d", k), (k % 3 == 0) ? 2 : (k % 3 == 1) ? 1 : 3,
                      (k % 3 == 2), 1'b1);
        end
        step(1'b1, '0, 1'b1);
        check_all("ar_load0", 0, 1'b1, 1'b0);
`endif

        // random stimulus against the model
        async_reset("rand_rst");
        for (int n = 0; n < 600; n++) begin
            bit            ld;
            bit            e;
            logic [CB-1:0] ini;
            if ($urandom_range(0, 79) == 0) begin
                async_reset($sformatf("rand_arst%0d", n));
            end
            ld  = ($urandom_range(0, 9) == 0);
            e   = ($urandom_range(0, 3) != 0);
            ini = CB'($urandom_range(0, 6));
            model_edge(ld, ini, e);
            step(ld, ini, e);
            check_all($sformatf("rand%0d", n), longint'(m_count), m_uf, m_active);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
